regbank_arb: RTL
================

Name: regbank_arb

Overview:
- Two-requester arbiter and sequencer for a bank of byte-write registers.
- Each requester (e.g. core CSR port and debug/bus port) issues single read or byte-masked write transactions.
- The block round-robins between requesters, performs the masked update and returns a response.
- Storage lives inside the block; all register contents are exported flat so downstream control logic can consume them.

Parameters:
- NREGS, 8, number of registers in the bank.
- WIDTH, 32, bits per register; need not be a multiple of 8.
- WSEL, ceil(WIDTH/8), byte-select lanes per register; the last lane covers the WIDTH%8 remainder bits when WIDTH%8 != 0.
- AW, 4, request address width; must satisfy 2**AW >= NREGS.

Ports:
- clk_i  in  1  clock.
- rstn_i  in  1  asynchronous active-low reset.
- req_valid_i  in  2  request valid, bit r = requester r.
- req_ready_o  out  2  request accepted when valid&ready.
- req_we_i  in  2  1 = write, 0 = read.
- req_addr_i  in  2*AW  register index, slice [r*AW +: AW].
- req_wsel_i  in  2*WSEL  byte lane enables.
- req_wdata_i  in  2*WIDTH  write data.
- rsp_valid_o  out  2  response valid, only toward the granted requester.
- rsp_ready_i  in  2  response consumed when valid&ready.
- rsp_rdata_o  out  WIDTH  read data, shared by both requesters.
- rsp_err_o  out  1  address out of range.
- regs_o  out  NREGS*WIDTH  current register contents, register k at [k*WIDTH +: WIDTH].

Behaviour:
- Reset (asynchronous, rstn_i low):
  - all registers = 0; rsp_valid_o = 0; rsp_rdata_o = 0; rsp_err_o = 0.
  - FSM = IDLE; priority pointer = requester 0.
  - req_ready_o is 0 while in reset.
- FSM has two states, IDLE and RESP.
- IDLE:
  - req_ready_o is combinational and one-hot at most.
  - Only one valid requester: it gets ready.
  - Both valid: the requester named by the priority pointer gets ready.
  - Neither valid: req_ready_o = 0.
  - On handshake (cycle T) the block latches grant id, address, we, wsel and wdata, performs the access, and moves to RESP at T+1.
- Access (executed at the T clock edge):
  - read: rsp_rdata_o = register value before any update.
  - write: for each lane i with wsel[i] = 1, register bits [8i +: min(8, WIDTH-8i)] take wdata; other bits hold. rsp_rdata_o = pre-write value, so a write also returns the old contents.
  - wsel all zero: write becomes a no-op, response still given, err = 0.
  - address >= NREGS: no state change, rsp_rdata_o = 0, rsp_err_o = 1.
- Timing: write effects are visible on regs_o at T+1, the same cycle rsp_valid_o[grant] rises. Minimum issue-to-response latency is 1 cycle.
- RESP:
  - req_ready_o = 0 for both requesters.
  - rsp_valid_o[grant] = 1; rsp_rdata_o and rsp_err_o are held stable until rsp_ready_i[grant].
  - On response handshake: rsp_valid_o clears next cycle, FSM returns to IDLE, and the priority pointer moves to the non-granted requester.
  - Maximum throughput: one transaction per 2 cycles.
- Round robin:
  - The pointer updates only on completed transactions.
  - A single requester issuing back-to-back transactions is never blocked when the other is idle.
  - Under contention both requesters alternate strictly.
- rsp_ready_i of the non-granted requester is ignored.
- Request inputs are sampled only at the handshake edge; changes while in RESP are ignored.
- Reset asserted mid-transaction: the response is dropped, registers return to 0, and the pointer returns to 0.

Test Plan:
- Reset then idle: regs_o all 0, req_ready_o = 00, rsp_valid_o = 00.
- Requester 0 writes addr 3, wsel = 4'b0101, wdata = 0xAABBCCDD, rsp_ready held 1:
  - response at T+1 with rdata = 0x00000000, err = 0.
  - regs_o[3] = 0x00BB00DD.
  - a following read of addr 3 returns 0x00BB00DD.
- Both requesters valid every cycle, each writing its own id to addr 0 for 4 transactions:
  - grants alternate 0,1,0,1.
  - each response routes only to the granted requester.
- Requester 1 reads addr 9 (NREGS = 8):
  - err = 1, rdata = 0.
  - regs_o unchanged.
- Backpressure: rsp_ready_i[0] = 0 for 5 cycles after a read of addr 3:
  - rsp_valid_o[0] and rdata held stable.
  - req_ready_o = 00 throughout.
  - completes the cycle after ready rises.
- WIDTH = 21, wsel = 3'b100, wdata = 0x1FFFFF: only bits [20:16] set, giving 0x1F0000. Then assert reset during RESP: all outputs return to reset values immediately.

Source files
------------

// File: rtl/regbank_arb_if.sv
// Two-requester register bank bus.
// Requesters drive master; the arbiter takes slave.
interface regbank_arb_if #(
  parameter int WIDTH = 32,
  parameter int WSEL  = (WIDTH + 7) / 8,
  parameter int AW    = 4
) ();
  logic [1:0]         req_valid_i;
  logic [1:0]         req_ready_o;
  logic [1:0]         req_we_i;
  logic [2*AW-1:0]    req_addr_i;
  logic [2*WSEL-1:0]  req_wsel_i;
  logic [2*WIDTH-1:0] req_wdata_i;
  logic [1:0]         rsp_valid_o;
  logic [1:0]         rsp_ready_i;
  logic [WIDTH-1:0]   rsp_rdata_o;
  logic               rsp_err_o;

  modport master (
    output req_valid_i, req_we_i, req_addr_i,
    output req_wsel_i, req_wdata_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o,
    input  rsp_rdata_o, rsp_err_o
  );

  modport slave (
    input  req_valid_i, req_we_i, req_addr_i,
    input  req_wsel_i, req_wdata_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o,
    output rsp_rdata_o, rsp_err_o
  );
endinterface

// File: rtl/regbank_arb.sv
// Round-robin arbiter for two requesters over
// a byte-write register bank with flat export.
module regbank_arb #(
  parameter int NREGS = 8,
  parameter int WIDTH = 32,
  parameter int WSEL  = (WIDTH + 7) / 8,
  parameter int AW    = 4
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  regbank_arb_if.slave           bus,
  output logic [NREGS*WIDTH-1:0] regs_o
);
  localparam int IW = (NREGS > 1) ? $clog2(NREGS) : 1;

  typedef enum logic {IDLE, RESP} state_t;

  state_t           state, state_nx;
  logic             ptr, ptr_nx;
  logic             grant;
  logic [1:0]       ready;
  logic             gid, hs, rsp_hs;
  logic [AW-1:0]    addr;
  logic             we;
  logic [WSEL-1:0]  wsel;
  logic [WIDTH-1:0] wdata, mask, cur;
  logic             hit;
  logic [WIDTH-1:0] rdata;
  logic             err;
  logic [WIDTH-1:0] regs [NREGS];

  // Pick at most one requester while idle.
  always_comb begin
    ready = 2'b00;
    if (rstn_i && state == IDLE) begin
      unique case (bus.req_valid_i)
        2'b01:   ready = 2'b01;
        2'b10:   ready = 2'b10;
        2'b11:   ready = ptr ? 2'b10 : 2'b01;
        default: ready = 2'b00;
      endcase
    end
  end

  assign gid = ready[1];
  assign hs  = |(bus.req_valid_i & ready);

  // Steer the granted requester's fields.
  always_comb begin
    addr  = gid ? bus.req_addr_i[2*AW-1:AW]
                : bus.req_addr_i[AW-1:0];
    we    = bus.req_we_i[gid];
    wsel  = gid ? bus.req_wsel_i[2*WSEL-1:WSEL]
                : bus.req_wsel_i[WSEL-1:0];
    wdata = gid ? bus.req_wdata_i[2*WIDTH-1:WIDTH]
                : bus.req_wdata_i[WIDTH-1:0];
  end

  // Expand lane enables; last lane may be short.
  always_comb begin
    mask = '0;
    for (int b = 0; b < WIDTH; b++)
      mask[b] = wsel[b/8];
  end

  assign hit = (32'(addr) < NREGS);
  assign cur = hit ? regs[addr[IW-1:0]] : '0;

  assign rsp_hs = (state == RESP) &&
                  bus.rsp_ready_i[grant];

  // Next state and pointer.
  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    unique case (state)
      IDLE: if (hs) state_nx = RESP;
      RESP: if (rsp_hs) begin
        state_nx = IDLE;
        ptr_nx   = ~grant;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Control registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state <= IDLE;
      ptr   <= 1'b0;
    end else begin
      state <= state_nx;
      ptr   <= ptr_nx;
    end
  end

  // Access on handshake; response held in RESP.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      grant <= 1'b0;
      rdata <= '0;
      err   <= 1'b0;
      for (int k = 0; k < NREGS; k++)
        regs[k] <= '0;
    end else if (hs) begin
      grant <= gid;
      if (hit) begin
        rdata <= cur;
        err   <= 1'b0;
        if (we)
          regs[addr[IW-1:0]] <=
            (cur & ~mask) | (wdata & mask);
      end else begin
        rdata <= '0;
        err   <= 1'b1;
      end
    end
  end

  assign bus.req_ready_o = ready;
  assign bus.rsp_valid_o =
    (state == RESP) ? (grant ? 2'b10 : 2'b01)
                    : 2'b00;
  assign bus.rsp_rdata_o = rdata;
  assign bus.rsp_err_o   = err;

  for (genvar k = 0; k < NREGS; k++) begin : g_exp
    assign regs_o[k*WIDTH +: WIDTH] = regs[k];
  end
endmodule
